// File: rtl/packet_pkg.sv
// Shared sizing constants and arbiter state encoding for the packet output path.
package packet_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 32;
    localparam int STALL_MAX  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit starting at ptr+1, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx = ptr;
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = W'((int'(ptr) + k) % N);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Packet-level round-robin arbiter for one output: holds a port until eop or stall timeout.
module output_arbiter #(
    parameter int ADDR_WIDTH = packet_pkg::ADDR_WIDTH,
    parameter int STALL_MAX  = packet_pkg::STALL_MAX,
    localparam int SEL_W     = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1,
    localparam int CNT_W     = $clog2(STALL_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] req,
    input  logic [ADDR_WIDTH-1:0] eop,
    output logic [SEL_W-1:0]      mux_sel,
    output logic                  arb_active,
    output logic [ADDR_WIDTH-1:0] grant,
    output logic                  pkt_done,
    output logic                  stall_abort
);

    import packet_pkg::*;

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic [SEL_W-1:0] mux_sel_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             beat;

    rr_pick #(
        .N (ADDR_WIDTH),
        .W (SEL_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign beat = (state_reg == OWN) && req[mux_sel];

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_grant
            assign grant[gi] = beat && (mux_sel == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= SEL_W'(ADDR_WIDTH - 1);
            mux_sel       <= '0;
            stall_cnt_reg <= '0;
            arb_active    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            mux_sel       <= mux_sel_next;
            stall_cnt_reg <= stall_cnt_next;
            arb_active    <= (state_next == OWN);
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        mux_sel_next   = mux_sel;
        stall_cnt_next = stall_cnt_reg;
        pkt_done       = 1'b0;
        stall_abort    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next     = OWN;
                    mux_sel_next   = pick_idx;
                    stall_cnt_next = '0;
                end
            end
            OWN: begin
                if (beat) begin
                    stall_cnt_next = '0;
                    if (eop[mux_sel]) begin
                        pkt_done   = 1'b1;
                        ptr_next   = mux_sel;
                        state_next = IDLE;
                    end
                end else if (stall_cnt_reg == CNT_W'(STALL_MAX - 1)) begin
                    // Owner went silent too long: release so others are not starved.
                    stall_abort    = 1'b1;
                    ptr_next       = mux_sel;
                    stall_cnt_next = '0;
                    state_next     = IDLE;
                end else begin
                    stall_cnt_next = stall_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4 from packet_pkg: number of input ports competing for this output.
REQ-002 Parameter STALL_MAX, default 16 from packet_pkg: consecutive stall cycles before forced release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  ADDR_WIDTH  per-port request; port i has a beat ready for this output.
REQ-006 eop  input  ADDR_WIDTH  per-port end-of-packet; qualifies the current beat of port i as the last beat.
REQ-007 mux_sel  output  $clog2(ADDR_WIDTH)  registered index of the granted port; drives the output mux select.
REQ-008 arb_active  output  1  registered; high while a port owns the output; drives the output mux gate.
REQ-009 grant  output  ADDR_WIDTH  one-hot pop strobe to the granted port's buffer.
REQ-010 pkt_done  output  1  one-cycle pulse when a packet completes normally.
REQ-011 stall_abort  output  1  one-cycle pulse when ownership is revoked by stall timeout.

Function
REQ-012 The FSM SHALL have two states: IDLE and OWN.
REQ-013 In IDLE with any req bit high, the block SHALL select the first requester in round-robin order starting at ptr+1 (mod ADDR_WIDTH), load mux_sel with it, and enter OWN on the next edge.
REQ-014 Latency: req rising in cycle N SHALL produce arb_active=1 and a valid mux_sel in cycle N+1.
REQ-015 In IDLE with req=0, state, mux_sel and ptr SHALL hold.
REQ-016 arb_active SHALL be 1 exactly when state is OWN.
REQ-017 grant SHALL be combinational: one-hot at mux_sel when state=OWN and req[mux_sel]=1; otherwise all zeros.
REQ-018 A beat SHALL be defined as state=OWN and req[mux_sel]=1; each beat consumes one entry from the granted port.
REQ-019 A beat with eop[mux_sel]=1 SHALL end ownership: pkt_done=1 in that cycle, ptr<=mux_sel, and state<=IDLE.
REQ-020 After every release, one IDLE cycle SHALL separate packets; back-to-back ownership is not permitted.
REQ-021 req and eop of non-granted ports SHALL be ignored while in OWN; a lost request remains pending and has no effect on the current owner.
REQ-022 stall_cnt ($clog2(STALL_MAX+1) bits) SHALL increment each OWN cycle with req[mux_sel]=0 and clear on any beat or on entry to OWN.
REQ-023 When stall_cnt reaches STALL_MAX-1 and req[mux_sel] is still 0, the block SHALL pulse stall_abort, set ptr<=mux_sel, and go to IDLE.
REQ-024 An eop without a beat (req[mux_sel]=0) SHALL be ignored.
REQ-025 pkt_done and stall_abort SHALL never assert in the same cycle.
REQ-026 mux_sel SHALL retain the last owner's index in IDLE; with arb_active=0 the downstream mux blanks the output.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, arb_active=0, mux_sel=0, grant=0, pkt_done=0, stall_abort=0, stall_cnt=0, ptr=ADDR_WIDTH-1, so port 0 has first priority.
REQ-028 Reset asserted mid-packet SHALL drop ownership without pulsing pkt_done or stall_abort; the partial packet is not resumed.
REQ-029 After rst deasserts, arbitration SHALL resume on the first clock edge.

Structure
REQ-030 ADDR_WIDTH, DATA_WIDTH, STALL_MAX and the FSM state enum (IDLE, OWN) SHALL live in packet_pkg.
REQ-031 The round-robin next-winner search SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs idx, any).
REQ-032 All outputs other than grant, pkt_done and stall_abort SHALL be register outputs.

Verification
REQ-033 After reset, req=4'b0001 held, eop on the 3rd beat -> arb_active rises one cycle later; mux_sel=0; grant=4'b0001 for 3 cycles; pkt_done on the 3rd beat; then 1 IDLE cycle; then re-grant.
REQ-034 req=4'b1111 continuously, every beat eop=1 -> grant order is port 0,1,2,3,0, with one IDLE cycle between grants.
REQ-035 Port 2 owns the output while port 1 requests; eop[1] toggles -> no effect on port 2; after port 2 ends, port 3 is chosen if requesting, otherwise port 1.
REQ-036 Owner drops req for 16 cycles -> stall_abort pulses once; state returns to IDLE; ptr advances past the owner; no pkt_done.
REQ-037 Owner stalls for 15 cycles, then sends a beat -> no abort; stall_cnt clears; the packet completes with pkt_done.
REQ-038 rst pulsed mid-packet on port 3 -> all outputs return to reset values asynchronously; the next grant with req=4'b1000 goes to port 3 one cycle after the first edge following reset release.
